vec_alu_sequencer: RTL and testbench



---
 rtl/vec_alu_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_vec_alu_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_alu_sequencer.sv
// vec_alu_sequencer
//   Runs an element-wise vector ALU over four internal DEPTH-entry memories.
//   A, B and OP are read at consecutive addresses starting at a base index,
//   and each result is written back into RESULT at the same index. Addresses
//   wrap modulo DEPTH.
//
// Ports
//   CLK                  sole clock, rising edge
//   RST                  asynchronous active-low reset (release is synchronised)
//   data_i               host write data for A, B and RESULT
//   addr_data_i          host address for A, B and RESULT
//   ena/wea_data_a_i     host enable / write-enable for A
//   ena/wea_data_b_i     host enable / write-enable for B
//   ena/wea_data_result_i host enable / write-enable for RESULT (ena & !wea = read)
//   data_o               RESULT read data, one cycle after the read request
//   op_i, addr_op_i      host opcode write data / address
//   ena_op_i, wea_op_i   host enable / write-enable for OP
//   base_i, len_i        first element index and element count (0..DEPTH)
//   start_i, abort_i     run control
//   busy_o, done_o, err_o run status
//   dbg_state            current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//
// Control handshake: in IDLE a high start_i is accepted at the clock edge and
// base_i/len_i are captured there. busy_o is high in RUN and DRAIN, during
// which start_i is ignored and host writes are dropped. done_o is high in
// DONE; the block stays in DONE while start_i is held high and returns to
// IDLE at the first edge that sees start_i low.
module vec_alu_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ADDR_WIDTH-1:0] addr_data_i,
  input  logic                  ena_data_a_i,
  input  logic                  wea_data_a_i,
  input  logic                  ena_data_b_i,
  input  logic                  wea_data_b_i,
  input  logic                  ena_data_result_i,
  input  logic                  wea_data_result_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic [OP_WIDTH-1:0]   op_i,
  input  logic [ADDR_WIDTH-1:0] addr_op_i,
  input  logic                  ena_op_i,
  input  logic                  wea_op_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            dbg_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int SHW   = $clog2(DATA_WIDTH);

  localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_SLL  = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_SRL  = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_SLT  = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_SRA  = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_SLTU = OP_WIDTH'(9);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Reset synchroniser: assertion passes straight through (the flops clear
  // asynchronously), release needs two rising edges to propagate.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // ---------------------------------------------------------------------------
  // Storage (contents are never reset)
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_a   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_b   [DEPTH];
  logic [OP_WIDTH-1:0]   mem_op  [DEPTH];
  logic [DATA_WIDTH-1:0] mem_res [DEPTH];

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] rd_addr;   // next element address, wraps naturally
  logic [ADDR_WIDTH:0]   remain;    // elements still to be read
  logic                  issue;     // a read is issued at this edge
  logic                  accept;    // a start is accepted at this edge
  logic                  host_ok;

  // Pipeline stage between read and write-back
  logic                  p_valid;
  logic [ADDR_WIDTH-1:0] p_addr;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [OP_WIDTH-1:0]   op_q;

  logic [DATA_WIDTH-1:0] alu_res;
  logic                  op_bad;

  assign accept  = (state == IDLE) && start_i;
  assign issue   = (state == RUN) && !abort_i;
  assign host_ok = !busy_o;

  // FSM: state register
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_i) state_next = (len_i == '0) ? DONE : RUN;
      end
      RUN: begin
        // Leave after the last read, or straight away on abort.
        if (abort_i || remain == (ADDR_WIDTH+1)'(1)) state_next = DRAIN;
      end
      DRAIN: begin
        // The final write commits at the edge that clears p_valid; DONE follows.
        if (!p_valid) state_next = DONE;
      end
      DONE: begin
        if (!start_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o    = 1'b0;
    done_o    = 1'b0;
    dbg_state = state;
    case (state)
      RUN, DRAIN: busy_o = 1'b1;
      DONE:       done_o = 1'b1;
      default: begin
        busy_o = 1'b0;
        done_o = 1'b0;
      end
    endcase
  end

  // Address/count bookkeeping, pipeline valid and sticky error
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      remain  <= '0;
      p_valid <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      p_valid <= issue;
      if (accept) begin
        rd_addr <= base_i;
        remain  <= len_i;
      end else if (issue) begin
        rd_addr <= rd_addr + ADDR_WIDTH'(1);
        remain  <= remain - (ADDR_WIDTH+1)'(1);
      end
      if (accept)                err_o <= 1'b0;
      else if (p_valid && op_bad) err_o <= 1'b1;
    end
  end

  // Read stage: operands are captured together with their write-back address
  always_ff @(posedge CLK) begin
    if (issue) begin
      a_q    <= mem_a[rd_addr];
      b_q    <= mem_b[rd_addr];
      op_q   <= mem_op[rd_addr];
      p_addr <= rd_addr;
    end
  end

  // ALU
  always_comb begin
    alu_res = '0;
    op_bad  = 1'b0;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_SLL:  alu_res = a_q << b_q[SHW-1:0];
      OP_SRL:  alu_res = a_q >> b_q[SHW-1:0];
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SRA:  alu_res = $signed(a_q) >>> b_q[SHW-1:0];
      OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (a_q < b_q)};
      default: begin
        alu_res = '0;
        op_bad  = 1'b1;
      end
    endcase
  end

  // Memory writes. Host writes only land while idle; the pipeline write-back
  // is the only writer of RESULT during a run. p_valid is cleared by reset,
  // so nothing is written back once RST has fallen.
  always_ff @(posedge CLK) begin
    if (host_ok && ena_data_a_i && wea_data_a_i) mem_a[addr_data_i] <= data_i;
    if (host_ok && ena_data_b_i && wea_data_b_i) mem_b[addr_data_i] <= data_i;
    if (host_ok && ena_op_i && wea_op_i)         mem_op[addr_op_i]  <= op_i;
    if (p_valid)
      mem_res[p_addr] <= alu_res;
    else if (host_ok && ena_data_result_i && wea_data_result_i)
      mem_res[addr_data_i] <= data_i;
  end

  // Host RESULT read port
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) data_o <= '0;
    else if (ena_data_result_i && !wea_data_result_i) data_o <= mem_res[addr_data_i];
  end

endmodule

// File: tb/tb_vec_alu_sequencer.sv
module tb_vec_alu_sequencer;

  logic        CLK;
  logic        RST;
  logic [31:0] data_i;
  logic [9:0]  addr_data_i;
  logic        ena_data_a_i, wea_data_a_i;
  logic        ena_data_b_i, wea_data_b_i;
  logic        ena_data_result_i, wea_data_result_i;
  logic [31:0] data_o;
  logic [3:0]  op_i;
  logic [9:0]  addr_op_i;
  logic        ena_op_i, wea_op_i;
  logic [9:0]  base_i;
  logic [10:0] len_i;
  logic        start_i, abort_i;
  logic        busy_o, done_o, err_o;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  vec_alu_sequencer dut (
    .CLK               (CLK),
    .RST               (RST),
    .data_i            (data_i),
    .addr_data_i       (addr_data_i),
    .ena_data_a_i      (ena_data_a_i),
    .wea_data_a_i      (wea_data_a_i),
    .ena_data_b_i      (ena_data_b_i),
    .wea_data_b_i      (wea_data_b_i),
    .ena_data_result_i (ena_data_result_i),
    .wea_data_result_i (wea_data_result_i),
    .data_o            (data_o),
    .op_i              (op_i),
    .addr_op_i         (addr_op_i),
    .ena_op_i          (ena_op_i),
    .wea_op_i          (wea_op_i),
    .base_i            (base_i),
    .len_i             (len_i),
    .start_i           (start_i),
    .abort_i           (abort_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .err_o             (err_o),
    .dbg_state         (dbg_state)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic clear_inputs();
    data_i = '0; addr_data_i = '0; op_i = '0; addr_op_i = '0;
    ena_data_a_i = 0; wea_data_a_i = 0; ena_data_b_i = 0; wea_data_b_i = 0;
    ena_data_result_i = 0; wea_data_result_i = 0; ena_op_i = 0; wea_op_i = 0;
    base_i = '0; len_i = '0; start_i = 0; abort_i = 0;
  endtask

  task automatic wr_a(input int addr, input logic [31:0] d);
    addr_data_i = 10'(addr); data_i = d; ena_data_a_i = 1; wea_data_a_i = 1;
    tick();
    ena_data_a_i = 0; wea_data_a_i = 0;
  endtask

  task automatic wr_b(input int addr, input logic [31:0] d);
    addr_data_i = 10'(addr); data_i = d; ena_data_b_i = 1; wea_data_b_i = 1;
    tick();
    ena_data_b_i = 0; wea_data_b_i = 0;
  endtask

  task automatic wr_r(input int addr, input logic [31:0] d);
    addr_data_i = 10'(addr); data_i = d; ena_data_result_i = 1; wea_data_result_i = 1;
    tick();
    ena_data_result_i = 0; wea_data_result_i = 0;
  endtask

  task automatic wr_op(input int addr, input logic [3:0] o);
    addr_op_i = 10'(addr); op_i = o; ena_op_i = 1; wea_op_i = 1;
    tick();
    ena_op_i = 0; wea_op_i = 0;
  endtask

  task automatic rd_r(input int addr, output logic [31:0] d);
    addr_data_i = 10'(addr); ena_data_result_i = 1; wea_data_result_i = 0;
    tick();
    ena_data_result_i = 0;
    d = data_o;
  endtask

  // Start a run, release start, and count edges until done_o (bounded).
  task automatic run_wait(input int base, input int len, output int cyc);
    base_i = 10'(base); len_i = 11'(len); start_i = 1;
    tick();
    start_i = 0;
    cyc = 0;
    while (!done_o && cyc < 1200) begin
      tick();
      cyc++;
    end
    tick();  // DONE -> IDLE
  endtask

  logic [31:0] rd;
  int          cyc;
  logic [31:0] blk_exp [8];

  initial begin
    blk_exp[0] = 32'h3; blk_exp[1] = 32'hFFFF_FFFF; blk_exp[2] = 32'h0; blk_exp[3] = 32'h3;
    blk_exp[4] = 32'h4; blk_exp[5] = 32'h0;         blk_exp[6] = 32'h1; blk_exp[7] = 32'h3;

    // Reset state
    clear_inputs();
    RST = 0;
    #2;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    tick();
    RST = 1;
    repeat (3) tick();

    // Full run: A=1, B=2, OP blocks of 128 = ADD..XOR
    for (int i = 0; i < 1024; i++) begin
      addr_data_i = 10'(i); data_i = 32'd1; ena_data_a_i = 1; wea_data_a_i = 1;
      addr_op_i = 10'(i); op_i = 4'(i / 128); ena_op_i = 1; wea_op_i = 1;
      tick();
    end
    ena_data_a_i = 0; wea_data_a_i = 0; ena_op_i = 0; wea_op_i = 0;
    for (int i = 0; i < 1024; i++) begin
      addr_data_i = 10'(i); data_i = 32'd2; ena_data_b_i = 1; wea_data_b_i = 1;
      tick();
    end
    ena_data_b_i = 0; wea_data_b_i = 0;

    base_i = 10'd0; len_i = 11'd1024; start_i = 1;
    tick();
    start_i = 0;
    check("full_busy_after_start", 32'(busy_o), 32'd1);
    check("full_done_low_after_start", 32'(done_o), 32'd0);
    cyc = 0;
    while (!done_o && cyc < 1200) begin
      tick();
      cyc++;
    end
    check("full_done_cycles", 32'(cyc), 32'd1026);
    check("full_busy_in_done", 32'(busy_o), 32'd0);
    tick();
    check("full_back_idle", 32'(dbg_state), 32'd0);
    check("full_err", 32'(err_o), 32'd0);
    for (int j = 0; j < 8; j++) begin
      rd_r(j * 128 + 5, rd);
      check($sformatf("full_blk%0d_a", j), rd, blk_exp[j]);
      rd_r(j * 128 + 127, rd);
      check($sformatf("full_blk%0d_b", j), rd, blk_exp[j]);
    end

    // Wrap-around run: base 1020, len 8, A=5, B=1, ADD
    for (int i = 0; i < 8; i++) begin
      wr_a((1020 + i) % 1024, 32'd5);
      wr_b((1020 + i) % 1024, 32'd1);
      wr_op((1020 + i) % 1024, 4'd0);
    end
    wr_r(4, 32'hAA);
    wr_r(1019, 32'hBB);
    run_wait(1020, 8, cyc);
    check("wrap_done_cycles", 32'(cyc), 32'd10);
    rd_r(1020, rd); check("wrap_r1020", rd, 32'd6);
    rd_r(1023, rd); check("wrap_r1023", rd, 32'd6);
    rd_r(0, rd);    check("wrap_r0", rd, 32'd6);
    rd_r(3, rd);    check("wrap_r3", rd, 32'd6);
    rd_r(4, rd);    check("wrap_r4_untouched", rd, 32'hAA);
    rd_r(1019, rd); check("wrap_r1019_untouched", rd, 32'hBB);

    // SRA / SLT / SLTU and an illegal opcode
    for (int i = 10; i < 14; i++) begin
      wr_a(i, 32'h8000_0000);
      wr_b(i, 32'd1);
    end
    wr_op(10, 4'd8);
    wr_op(11, 4'd6);
    wr_op(12, 4'd9);
    wr_op(13, 4'd12);
    run_wait(10, 4, cyc);
    check("ops_done_cycles", 32'(cyc), 32'd6);
    check("ops_err_set", 32'(err_o), 32'd1);
    rd_r(10, rd); check("ops_sra", rd, 32'hC000_0000);
    rd_r(11, rd); check("ops_slt", rd, 32'd1);
    rd_r(12, rd); check("ops_sltu", rd, 32'd0);
    rd_r(13, rd); check("ops_illegal", rd, 32'd0);
    check("ops_err_sticky", 32'(err_o), 32'd1);
    base_i = 10'd1020; len_i = 11'd1; start_i = 1;
    tick();
    start_i = 0;
    check("ops_err_cleared", 32'(err_o), 32'd0);
    repeat (4) tick();

    // Zero-length run with start held
    base_i = 10'd0; len_i = 11'd0; start_i = 1;
    tick();
    check("len0_done", 32'(done_o), 32'd1);
    check("len0_busy", 32'(busy_o), 32'd0);
    repeat (3) tick();
    check("len0_done_held", 32'(done_o), 32'd1);
    start_i = 0;
    tick();
    check("len0_done_dropped", 32'(done_o), 32'd0);
    check("len0_idle", 32'(dbg_state), 32'd0);
    rd_r(0, rd); check("len0_r0_unchanged", rd, 32'd6);

    // Abort after three reads; host writes during the run are dropped
    for (int i = 50; i < 55; i++) wr_r(i, 32'hDEAD);
    wr_r(60, 32'hDEAD);
    base_i = 10'd50; len_i = 11'd100; start_i = 1;
    tick();
    start_i = 0;
    check("abort_busy", 32'(busy_o), 32'd1);
    addr_data_i = 10'd51; data_i = 32'h100; ena_data_a_i = 1; wea_data_a_i = 1;
    tick();
    ena_data_a_i = 0; wea_data_a_i = 0;
    addr_data_i = 10'd60; data_i = 32'h5555; ena_data_result_i = 1; wea_data_result_i = 1;
    tick();
    ena_data_result_i = 0; wea_data_result_i = 0;
    tick();
    abort_i = 1;
    tick();
    abort_i = 0;
    cyc = 0;
    while (!done_o && cyc < 20) begin
      tick();
      cyc++;
    end
    check("abort_done", 32'(done_o), 32'd1);
    tick();
    rd_r(50, rd); check("abort_r50", rd, 32'd3);
    rd_r(51, rd); check("abort_r51_a_write_ignored", rd, 32'd3);
    rd_r(52, rd); check("abort_r52", rd, 32'd3);
    rd_r(53, rd); check("abort_r53_not_written", rd, 32'hDEAD);
    rd_r(54, rd); check("abort_r54_not_written", rd, 32'hDEAD);
    rd_r(60, rd); check("abort_r60_host_ignored", rd, 32'hDEAD);

    // Reset in the middle of a full run (element 13 is still illegal)
    wr_r(500, 32'h77);
    base_i = 10'd0; len_i = 11'd1024; start_i = 1;
    tick();
    start_i = 0;
    repeat (20) tick();
    check("midrst_err_before", 32'(err_o), 32'd1);
    check("midrst_data_before", data_o, 32'hDEAD);
    #3;
    RST = 0;
    #1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_done", 32'(done_o), 32'd0);
    check("midrst_err", 32'(err_o), 32'd0);
    check("midrst_data", data_o, 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    tick();
    len_i = 11'd0; start_i = 1;
    #2;
    RST = 1;
    tick();
    check("rel_no_change_edge1", 32'(done_o), 32'd0);
    cyc = 0;
    while (!done_o && cyc < 5) begin
      tick();
      cyc++;
    end
    check("rel_done_eventually", 32'(done_o), 32'd1);
    start_i = 0;
    tick();
    rd_r(500, rd); check("midrst_r500_kept", rd, 32'h77);

    // Full run after the reset completes normally
    wr_op(13, 4'd0);
    run_wait(0, 1024, cyc);
    check("rerun_done_cycles", 32'(cyc), 32'd1026);
    check("rerun_err", 32'(err_o), 32'd0);
    for (int j = 0; j < 8; j++) begin
      rd_r(j * 128 + 64, rd);
      check($sformatf("rerun_blk%0d", j), rd, blk_exp[j]);
    end
    rd_r(500, rd); check("rerun_r500", rd, blk_exp[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
